lif_spike_gen: RTL and testbench

Layer-output spike generator. Consumes the per-output-row current vector produced by the pipelined spike MAC and integrates it into an array of leaky integrate-and-fire (LIF) neurons. The block emits a registered spike vector suitable as the `spikes` input of the next layer's MAC. It is the transmitting end of the spike interface; the MAC is the receiving end.

---
 rtl/lif_spike_gen_pkg.sv | 20 ++
 rtl/lif_spike_gen_if.sv | 24 ++
 rtl/lif_spike_gen_neuron.sv | 61 ++++++
 rtl/lif_spike_gen.sv | 60 ++++++
 tb/tb_lif_spike_gen.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lif_spike_gen_pkg.sv
// Shared DPE parameters and types for the spike MAC and LIF layer output.
package DPE_params;
  localparam int OUTPUT_VEC_LEN = 4;
  localparam int WIDTH = 8;
  localparam int POT_WIDTH = WIDTH + 2;

  typedef logic signed [POT_WIDTH-1:0] pot_t;
  typedef logic signed [WIDTH-1:0] cur_t;

  function automatic int sat_hi(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_lo(input int w);
    return -(1 << (w - 1));
  endfunction

  localparam pot_t POT_MAX = pot_t'(sat_hi(POT_WIDTH));
  localparam pot_t POT_MIN = pot_t'(sat_lo(POT_WIDTH));
endpackage

// File: rtl/lif_spike_gen_if.sv
// Step interface between the spike MAC output and the LIF spike generator.
interface lif_spike_gen_if #(
  parameter int N = 4,
  parameter int WIDTH = 8,
  parameter int POT_WIDTH = 10
);
  logic in_valid;
  logic [N-1:0][WIDTH-1:0] currents;
  logic signed [POT_WIDTH-1:0] threshold;
  logic clear;
  logic out_valid;
  logic [N-1:0] spikes;
  logic [N-1:0][POT_WIDTH-1:0] potentials;

  modport master (
    output in_valid, currents, threshold, clear,
    input out_valid, spikes, potentials
  );

  modport slave (
    input in_valid, currents, threshold, clear,
    output out_valid, spikes, potentials
  );
endinterface

// File: rtl/lif_spike_gen_neuron.sv
// One leaky integrate-and-fire neuron: potential, refractory count,
// saturating update datapath.
module lif_neuron
  import DPE_params::*;
#(
  parameter int WIDTH = DPE_params::WIDTH,
  parameter int POT_WIDTH = DPE_params::POT_WIDTH,
  parameter int LEAK_SHIFT = 2,
  parameter int REFRACT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_step,
  input  logic i_clear,
  input  logic signed [WIDTH-1:0] i_cur,
  input  logic signed [POT_WIDTH-1:0] i_thr,
  output logic o_spike,
  output logic signed [POT_WIDTH-1:0] o_v
);
  localparam int EW = POT_WIDTH + 2;
  localparam int RC_W = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
  localparam logic signed [POT_WIDTH-1:0] P_HI =
    POT_WIDTH'(sat_hi(POT_WIDTH));
  localparam logic signed [POT_WIDTH-1:0] P_LO =
    POT_WIDTH'(sat_lo(POT_WIDTH));

  logic signed [POT_WIDTH-1:0] r_v;
  logic [RC_W-1:0] r_rc;
  logic signed [EW-1:0] w_sum;
  logic signed [POT_WIDTH-1:0] w_sat;
  logic w_fire;

  // Two guard bits keep v - leak + current exact before clamping.
  always_comb begin
    w_sum = EW'(r_v) - EW'(r_v >>> LEAK_SHIFT) + EW'(i_cur);
    w_sat = w_sum[POT_WIDTH-1:0];
    if (w_sum > EW'(P_HI)) w_sat = P_HI;
    else if (w_sum < EW'(P_LO)) w_sat = P_LO;
    w_fire = (r_rc == '0) && (w_sat >= i_thr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || i_clear) begin
      r_v <= '0;
      r_rc <= '0;
    end else if (i_step) begin
      if (r_rc != '0) begin
        r_rc <= r_rc - 1'b1;
        r_v <= '0;
      end else if (w_fire) begin
        r_v <= '0;
        r_rc <= RC_W'(REFRACT);
      end else begin
        r_v <= w_sat;
      end
    end
  end

  assign o_spike = w_fire;
  assign o_v = r_v;
endmodule

// File: rtl/lif_spike_gen.sv
// Layer-output spike generator: N LIF neurons fed by the MAC current
// vector, with registered spike vector and step-valid flag.
module lif_spike_gen
  import DPE_params::*;
#(
  parameter int N = DPE_params::OUTPUT_VEC_LEN,
  parameter int WIDTH = DPE_params::WIDTH,
  parameter int POT_WIDTH = WIDTH + 2,
  parameter int LEAK_SHIFT = 2,
  parameter int REFRACT = 2
) (
  input logic clk,
  input logic rst_n,
  lif_spike_gen_if.slave bus
);
  logic w_step;
  logic [N-1:0] w_spike;
  logic signed [POT_WIDTH-1:0] w_pot [N];
  logic [N-1:0] r_spikes;
  logic r_out_valid;

  // A clear in the same cycle as in_valid drops that step.
  assign w_step = bus.in_valid && !bus.clear;

  for (genvar g = 0; g < N; g++) begin : g_n
    lif_neuron #(
      .WIDTH(WIDTH),
      .POT_WIDTH(POT_WIDTH),
      .LEAK_SHIFT(LEAK_SHIFT),
      .REFRACT(REFRACT)
    ) u_neuron (
      .clk(clk),
      .rst_n(rst_n),
      .i_step(w_step),
      .i_clear(bus.clear),
      .i_cur(bus.currents[g]),
      .i_thr(bus.threshold),
      .o_spike(w_spike[g]),
      .o_v(w_pot[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n || bus.clear) begin
      r_spikes <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_step;
      if (w_step) r_spikes <= w_spike;
    end
  end

  always_comb begin
    bus.potentials = '0;
    for (int i = 0; i < N; i++) bus.potentials[i] = w_pot[i];
  end

  assign bus.spikes = r_spikes;
  assign bus.out_valid = r_out_valid;
endmodule

// File: tb/tb_lif_spike_gen.sv
// Directed bench for lif_spike_gen, LEAK_SHIFT 2 and 7, against a rule model.
module tb_lif_spike_gen;
  localparam int N = 4;
  localparam int W = 8;
  localparam int PW = 10;
  localparam int REF = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;
  logic clear;
  int cur [N];
  int thr;
  bit chk_en = 1'b0;
  int ntests = 0;
  int nfail = 0;

  int mv [2][N];
  int mrc [2][N];
  logic exp_ov [2];
  logic [N-1:0] exp_sp [2];
  int ls [2] = '{2, 7};

  always #5 clk = ~clk;

  lif_spike_gen_if #(.N(N), .WIDTH(W), .POT_WIDTH(PW)) bus0 ();
  lif_spike_gen_if #(.N(N), .WIDTH(W), .POT_WIDTH(PW)) bus1 ();

  lif_spike_gen #(
    .N(N), .WIDTH(W), .POT_WIDTH(PW), .LEAK_SHIFT(2), .REFRACT(REF)
  ) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  lif_spike_gen #(
    .N(N), .WIDTH(W), .POT_WIDTH(PW), .LEAK_SHIFT(7), .REFRACT(REF)
  ) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  always_comb begin
    bus0.in_valid = in_valid;
    bus1.in_valid = in_valid;
    bus0.clear = clear;
    bus1.clear = clear;
    bus0.threshold = PW'(thr);
    bus1.threshold = PW'(thr);
    bus0.currents = '0;
    bus1.currents = '0;
    for (int i = 0; i < N; i++) begin
      bus0.currents[i] = W'(cur[i]);
      bus1.currents[i] = W'(cur[i]);
    end
  end

  task automatic check(input string nm, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  // Rule model: one timestep of every neuron, for both leak settings.
  task automatic mstep();
    int s;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n || clear) begin
        exp_ov[d] = 1'b0;
        exp_sp[d] = '0;
        for (int i = 0; i < N; i++) begin
          mv[d][i] = 0;
          mrc[d][i] = 0;
        end
      end else if (in_valid) begin
        exp_ov[d] = 1'b1;
        for (int i = 0; i < N; i++) begin
          if (mrc[d][i] != 0) begin
            mrc[d][i]--;
            mv[d][i] = 0;
            exp_sp[d][i] = 1'b0;
          end else begin
            s = mv[d][i] - (mv[d][i] >>> ls[d]) + cur[i];
            if (s > 511) s = 511;
            if (s < -512) s = -512;
            if (s >= thr) begin
              exp_sp[d][i] = 1'b1;
              mv[d][i] = 0;
              mrc[d][i] = REF;
            end else begin
              exp_sp[d][i] = 1'b0;
              mv[d][i] = s;
            end
          end
        end
      end else begin
        exp_ov[d] = 1'b0;
      end
    end
  endtask

  task automatic cmp_dut(input int d, input logic ov,
                         input logic [N-1:0] sp,
                         input logic [N*PW-1:0] pot);
    check($sformatf("d%0d.out_valid", d), 32'(ov), 32'(exp_ov[d]));
    check($sformatf("d%0d.spikes", d), 32'(sp), 32'(exp_sp[d]));
    if (exp_ov[d] === 1'b1)
      for (int i = 0; i < N; i++)
        check($sformatf("d%0d.pot%0d", d, i),
              32'($signed(pot[i*PW +: PW])), mv[d][i]);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_dut(0, bus0.out_valid, bus0.spikes, bus0.potentials);
      cmp_dut(1, bus1.out_valid, bus1.spikes, bus1.potentials);
    end
  end

  task automatic cyc();
    @(posedge clk);
    mstep();
    #1;
  endtask

  task automatic do_clear();
    in_valid = 1'b0;
    clear = 1'b1;
    cyc();
    clear = 1'b0;
  endtask

  function automatic logic signed [31:0] p0(input int i);
    return 32'($signed(bus0.potentials[i]));
  endfunction

  int ia [7] = '{40, 70, 93, 0, 0, 0, 40};
  int lk [5] = '{80, 60, 45, 34, 26};
  int sat [5] = '{-128, -255, -381, -506, -512};
  int pv [N] = '{127, -5, 0, 50};

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    clear = 1'b0;
    thr = 100;
    for (int i = 0; i < N; i++) cur[i] = 0;
    cyc();
    chk_en = 1'b1;
    cyc();
    check("reset.out_valid", 32'(bus0.out_valid), 0);
    check("reset.spikes", 32'(bus0.spikes), 0);
    check("reset.pot0", p0(0), 0);
    rst_n = 1'b1;

    // Integrate and fire, then refractory.
    in_valid = 1'b1;
    cur[0] = 40;
    for (int k = 0; k < 7; k++) begin
      cyc();
      check($sformatf("fire.pot0.s%0d", k + 1), p0(0), ia[k]);
      check($sformatf("fire.spk0.s%0d", k + 1),
            32'(bus0.spikes[0]), (k == 3) ? 1 : 0);
    end
    do_clear();

    // Leak with idle gaps between steps.
    in_valid = 1'b1;
    cur[0] = 80;
    cyc();
    check("leak.pot0.s1", p0(0), lk[0]);
    cur[0] = 0;
    for (int k = 1; k < 5; k++) begin
      in_valid = 1'b0;
      cyc();
      check($sformatf("leak.gap%0d.pot0", k), p0(0), lk[k-1]);
      check($sformatf("leak.gap%0d.ov", k), 32'(bus0.out_valid), 0);
      in_valid = 1'b1;
      cyc();
      check($sformatf("leak.pot0.s%0d", k + 1), p0(0), lk[k]);
      check($sformatf("leak.spk.s%0d", k + 1), 32'(bus0.spikes), 0);
    end
    do_clear();

    // Negative saturation on the LEAK_SHIFT=7 instance.
    in_valid = 1'b1;
    cur[0] = -128;
    for (int k = 0; k < 5; k++) begin
      cyc();
      check($sformatf("sat.pot0.s%0d", k + 1),
            32'($signed(bus1.potentials[0])), sat[k]);
      check($sformatf("sat.spk.s%0d", k + 1), 32'(bus1.spikes), 0);
    end
    do_clear();

    // Clear collides with a valid step.
    in_valid = 1'b1;
    cur[0] = 40;
    repeat (3) cyc();
    check("clr.pre.pot0", p0(0), 93);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    check("clr.ov", 32'(bus0.out_valid), 0);
    check("clr.spikes", 32'(bus0.spikes), 0);
    cyc();
    check("clr.post.pot0", p0(0), 40);
    do_clear();

    // Reset while a neuron is refractory.
    in_valid = 1'b1;
    cur[0] = 40;
    repeat (4) cyc();
    check("rst.pre.spk0", 32'(bus0.spikes[0]), 1);
    rst_n = 1'b0;
    cyc();
    check("rst.ov", 32'(bus0.out_valid), 0);
    check("rst.spikes", 32'(bus0.spikes), 0);
    check("rst.pot0", p0(0), 0);
    rst_n = 1'b1;
    cur[0] = 110;
    cyc();
    check("rst.post.spk0", 32'(bus0.spikes[0]), 1);
    do_clear();

    // Parallel neurons; neuron3 reaches 116 on step 3.
    in_valid = 1'b1;
    for (int i = 0; i < N; i++) cur[i] = pv[i];
    cyc();
    check("par.s1.spikes", 32'(bus0.spikes), 32'h1);
    check("par.s1.pot3", p0(3), 50);
    cyc();
    check("par.s2.spikes", 32'(bus0.spikes), 0);
    check("par.s2.pot3", p0(3), 88);
    cyc();
    check("par.s3.spikes", 32'(bus0.spikes), 32'h8);
    check("par.s3.pot1", p0(1), -11);
    in_valid = 1'b0;
    cyc();
    cyc();
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
